// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the unified-memory port arbiter of the 5-stage MIPS
// pipeline: default bus widths, the arbiter FSM state encoding, the
// requester identifiers, and the width of the data-burst counter.
// ---------------------------------------------------------------------------
package mips_mem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   // Wide enough for MAX_DATA_BURST values up to 15.
   localparam int BURST_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DBUSY = 2'b01,
      IBUSY = 2'b10
   } arb_state_e;

   typedef logic req_id_t;

   localparam req_id_t REQ_IF = 1'b0;
   localparam req_id_t REQ_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (IF) and the
// data-memory stage (DM). One transaction is outstanding at a time; DM has
// priority, but after MAX_DATA_BURST consecutive DM grants made while a fetch
// is waiting, the fetch is served. A fetch cancelled by a taken branch still
// completes on the memory side, but its ack is swallowed.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   if_req/if_addr          fetch request and address (held until ack/cancel)
//   if_cancel               flush pulse, kills pending or in-flight fetch
//   if_rdata/if_ack         fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_be      load/store request, write enable, byte enables
//   dm_addr/dm_wdata        data address and store data
//   dm_rdata/dm_ack         load data and one-cycle completion pulse
//   mem_req..mem_wdata      registered memory request bus
//   mem_rdata/mem_ack       memory read data and completion pulse
//   stall_f, stall_m        stall requests towards the hazard unit
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   input  logic                  if_cancel,
   output logic [DATA_W-1:0]     if_rdata,
   output logic                  if_ack,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [DATA_W/8-1:0]   dm_be,
   input  logic [ADDR_W-1:0]     dm_addr,
   input  logic [DATA_W-1:0]     dm_wdata,
   output logic [DATA_W-1:0]     dm_rdata,
   output logic                  dm_ack,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_ack,
   output logic                  stall_f,
   output logic                  stall_m
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

   arb_state_e           state_q, state_d;
   logic                 mem_req_q, mem_req_d;
   logic                 mem_we_q, mem_we_d;
   logic [BE_W-1:0]      mem_be_q, mem_be_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
   logic [BURST_W-1:0]   burst_q, burst_d;
   logic                 drop_q, drop_d;

   logic                 grant;
   req_id_t              grant_id;

   // Arbitration is only evaluated in IDLE. A DM grant with a fetch waiting
   // is only possible while burst_q < BURST_MAX, so the plain increment can
   // never pass the limit: saturation falls out of the grant condition.
   // The drop flag remembers a cancel seen before the memory answered; a
   // cancel in the ack cycle itself is handled directly on if_ack.
   always_comb begin
      state_d   = state_q;
      mem_req_d = mem_req_q;
      burst_d   = burst_q;
      drop_d    = drop_q;
      grant     = 1'b0;
      grant_id  = REQ_IF;

      case (state_q)
         IDLE: begin
            if (dm_req && (!if_req || (burst_q < BURST_MAX))) begin
               grant    = 1'b1;
               grant_id = REQ_DM;
               state_d  = DBUSY;
               burst_d  = if_req ? (burst_q + BURST_W'(1)) : '0;
            end else if (if_req && !if_cancel) begin
               grant    = 1'b1;
               grant_id = REQ_IF;
               state_d  = IBUSY;
               burst_d  = '0;
            end
         end

         DBUSY: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end

         IBUSY: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               drop_d    = 1'b0;
            end else if (if_cancel) begin
               drop_d = 1'b1;
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            drop_d    = 1'b0;
         end
      endcase

      if (grant) begin
         mem_req_d = 1'b1;
      end
   end

   // The request payload is captured only on a grant, so the memory bus
   // never depends combinationally on the requesters and stays frozen for
   // the whole transaction. Fetches are full-word reads.
   always_comb begin
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (grant) begin
         if (grant_id == REQ_DM) begin
            mem_we_d    = dm_we;
            mem_be_d    = dm_be;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
         end else begin
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
         end
      end
   end

   // Asynchronous reset drops mem_req immediately, abandoning any
   // transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         burst_q     <= '0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         burst_q     <= burst_d;
         drop_q      <= drop_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Read data is passed straight through; it is only meaningful alongside
   // the corresponding ack.
   assign dm_rdata = mem_rdata;
   assign if_rdata = mem_rdata;

   assign dm_ack = (state_q == DBUSY) && mem_ack;
   assign if_ack = (state_q == IBUSY) && mem_ack && !drop_q && !if_cancel;

   assign stall_f = if_req && !if_ack && !if_cancel;
   assign stall_m = dm_req && !dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A transaction-level model tracks
// which requester owns the memory, what it asked for, how many DM grants
// have passed a waiting fetch, and whether the fetch was cancelled; a compare
// process checks every DUT output against it each cycle. Directed scenarios
// add hand-computed expectations on the observed transaction sequence.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int MAXB     = 4;
   localparam int OWN_NONE = 0;
   localparam int OWN_IF   = 1;
   localparam int OWN_DM   = 2;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_cancel;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;
   logic        stall_f;
   logic        stall_m;

   int checks   = 0;
   int failures = 0;

   int   memWait     = 0;
   logic memAckForce = 1'b0;
   int   memCnt      = 0;

   int          mOwner;
   int          mBurst;
   logic        mDrop;
   logic        mWe;
   logic [3:0]  mBe;
   logic [31:0] mAddr;
   logic [31:0] mWdata;

   logic expIf;
   logic expDm;
   logic lastIfAck = 1'b0;
   logic lastDmAck = 1'b0;
   logic prevReq   = 1'b0;
   int   cycleNo   = 0;
   int   memReqCycles = 0;

   logic [31:0] txCycle[$];
   logic [31:0] txAddr[$];
   logic [31:0] txAttr[$];
   logic [31:0] dmAckCyc[$];
   logic [31:0] ifAckCyc[$];
   logic [31:0] ifAckData[$];

   mem_port_arbiter #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .MAX_DATA_BURST (MAXB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_cancel (if_cancel),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_be     (dm_be),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ack    (dm_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .stall_f   (stall_f),
      .stall_m   (stall_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents as seen by the bench: two fixed words, everything else
   // derived from the address.
   function automatic logic [31:0] memRead(input logic [31:0] a);
      case (a)
         32'h0000_0040: return 32'h2008_0005;
         32'h0000_0080: return 32'h1234_5678;
         default:       return a ^ 32'hA5A5_0000;
      endcase
   endfunction

   function automatic logic [31:0] qAt(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hFFFF_FFFF;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                input logic ifCancel, input logic dmReq,
                                input logic dmWe, input logic [3:0] dmBe,
                                input logic [31:0] dmAddr, input logic [31:0] dmWdata);
      if_req    = ifReq;
      if_addr   = ifAddr;
      if_cancel = ifCancel;
      dm_req    = dmReq;
      dm_we     = dmWe;
      dm_be     = dmBe;
      dm_addr   = dmAddr;
      dm_wdata  = dmWdata;
   endtask

   task automatic clearLogs();
      txCycle.delete();
      txAddr.delete();
      txAttr.delete();
      dmAckCyc.delete();
      ifAckCyc.delete();
      ifAckData.delete();
      memReqCycles = 0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_mem_req"},   mem_req,   0);
      checkOutput({tag, "_mem_we"},    mem_we,    0);
      checkOutput({tag, "_mem_be"},    mem_be,    0);
      checkOutput({tag, "_mem_addr"},  mem_addr,  0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
      checkOutput({tag, "_if_ack"},    if_ack,    0);
      checkOutput({tag, "_dm_ack"},    dm_ack,    0);
   endtask

   // Behaves like the pipeline stages: keeps requests up, and after each
   // observed ack either issues the next request (next address) or drops it.
   task automatic serveRequests(input int nIf, input int nDm, input int maxCyc);
      int ifLeft;
      int dmLeft;
      int cyc;
      ifLeft = nIf;
      dmLeft = nDm;
      cyc    = 0;
      if_req = (ifLeft > 0);
      dm_req = (dmLeft > 0);
      while ((ifLeft > 0 || dmLeft > 0) && cyc < maxCyc) begin
         tick();
         cyc++;
         if (lastIfAck && ifLeft > 0) begin
            ifLeft--;
            if_addr = if_addr + 32'd4;
            if (ifLeft == 0) if_req = 1'b0;
         end
         if (lastDmAck && dmLeft > 0) begin
            dmLeft--;
            dm_addr = dm_addr + 32'd4;
            if (dmLeft == 0) dm_req = 1'b0;
         end
      end
      if (ifLeft > 0 || dmLeft > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL serve_timeout actual_outstanding=%0d/%0d required=0/0",
                  ifLeft, dmLeft);
      end
   endtask

   // Memory responder: acks memWait cycles after a request appears.
   always @(posedge clk) begin
      #1;
      if (mem_req) begin
         if (memCnt >= memWait) begin
            mem_ack   = 1'b1;
            mem_rdata = memRead(mem_addr);
            memCnt    = 0;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            memCnt++;
         end
      end else begin
         mem_ack   = memAckForce;
         mem_rdata = memAckForce ? 32'hBAD0_0000 : 32'h0;
         memCnt    = 0;
      end
   end

   // Transaction-level model: who owns the memory and with what request.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mOwner = OWN_NONE;
         mBurst = 0;
         mDrop  = 1'b0;
         mWe    = 1'b0;
         mBe    = 4'h0;
         mAddr  = 32'h0;
         mWdata = 32'h0;
      end else if (mOwner != OWN_NONE) begin
         if (mem_ack) begin
            mOwner = OWN_NONE;
            mDrop  = 1'b0;
         end else if (mOwner == OWN_IF && if_cancel) begin
            mDrop = 1'b1;
         end
      end else if (dm_req && (!if_req || mBurst < MAXB)) begin
         mOwner = OWN_DM;
         mWe    = dm_we;
         mBe    = dm_be;
         mAddr  = dm_addr;
         mWdata = dm_wdata;
         if (if_req) mBurst = (mBurst + 1 > MAXB) ? MAXB : mBurst + 1;
         else        mBurst = 0;
      end else if (if_req && !if_cancel) begin
         mOwner = OWN_IF;
         mWe    = 1'b0;
         mBe    = 4'hF;
         mAddr  = if_addr;
         mBurst = 0;
      end
   end

   // Per-cycle comparison against the model, plus logging of what the DUT did.
   always @(negedge clk) begin
      if (!rst_n) begin
         lastIfAck = 1'b0;
         lastDmAck = 1'b0;
         prevReq   = 1'b0;
      end else begin
         cycleNo++;
         expIf = (mOwner == OWN_IF) && mem_ack && !mDrop && !if_cancel;
         expDm = (mOwner == OWN_DM) && mem_ack;
         checkOutput("mem_req", mem_req, (mOwner != OWN_NONE));
         if (mOwner != OWN_NONE) begin
            checkOutput("mem_addr", mem_addr, mAddr);
            checkOutput("mem_we",   mem_we,   mWe);
            checkOutput("mem_be",   mem_be,   mBe);
            if (mOwner == OWN_DM) checkOutput("mem_wdata", mem_wdata, mWdata);
         end
         checkOutput("if_ack",  if_ack,  expIf);
         checkOutput("dm_ack",  dm_ack,  expDm);
         checkOutput("stall_f", stall_f, if_req && !expIf && !if_cancel);
         checkOutput("stall_m", stall_m, dm_req && !expDm);
         if (expIf) checkOutput("if_rdata", if_rdata, memRead(mAddr));
         if (expDm) checkOutput("dm_rdata", dm_rdata, memRead(mAddr));

         if (mem_req) memReqCycles++;
         if (mem_req && !prevReq) begin
            txCycle.push_back(cycleNo);
            txAddr.push_back(mem_addr);
            txAttr.push_back({27'b0, mem_we, mem_be});
         end
         if (dm_ack) dmAckCyc.push_back(cycleNo);
         if (if_ack) begin
            ifAckCyc.push_back(cycleNo);
            ifAckData.push_back(if_rdata);
         end
         prevReq   = mem_req;
         lastIfAck = if_ack;
         lastDmAck = dm_ack;
      end
   end

   initial begin
      logic [31:0] s3Exp [10];
      int dmGot;

      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) tick();
      checkResetValues("rst0");
      rst_n = 1'b1;
      tick();

      // Isolated fetch, memory answers two cycles after the request.
      clearLogs();
      memWait = 2;
      if_addr = 32'h0000_0040;
      serveRequests(1, 0, 40);
      repeat (2) tick();
      checkOutput("s1_req_cycles", memReqCycles, 3);
      checkOutput("s1_if_acks", ifAckCyc.size(), 1);
      checkOutput("s1_if_rdata", qAt(ifAckData, 0), 32'h2008_0005);
      checkOutput("s1_be_we", qAt(txAttr, 0), 32'h0F);

      // Stray memory ack while idle must be ignored.
      clearLogs();
      memAckForce = 1'b1;
      tick();
      memAckForce = 1'b0;
      repeat (2) tick();
      checkOutput("stray_acks", ifAckCyc.size() + dmAckCyc.size(), 0);
      checkOutput("stray_req_cycles", memReqCycles, 0);

      // Simultaneous store and fetch: store first, fetch after one idle cycle.
      clearLogs();
      memWait = 1;
      applyStimulus(1'b0, 32'h44, 1'b0, 1'b0, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
      serveRequests(1, 1, 40);
      repeat (2) tick();
      checkOutput("s2_tx_count", txAddr.size(), 2);
      checkOutput("s2_first_addr", qAt(txAddr, 0), 32'h100);
      checkOutput("s2_first_we_be", qAt(txAttr, 0), 32'h13);
      checkOutput("s2_second_addr", qAt(txAddr, 1), 32'h44);
      checkOutput("s2_second_we_be", qAt(txAttr, 1), 32'h0F);
      checkOutput("s2_if_after_dm", qAt(txCycle, 1) - qAt(dmAckCyc, 0), 2);

      // Starvation guard: 4 DM, 1 IF, 4 DM (counter restarted), then IF.
      clearLogs();
      memWait = 0;
      applyStimulus(1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 4'hF, 32'h200, 32'h0);
      serveRequests(2, 8, 200);
      repeat (2) tick();
      s3Exp = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h300,
                32'h210, 32'h214, 32'h218, 32'h21C, 32'h304};
      checkOutput("s3_tx_count", txAddr.size(), 10);
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("s3_tx%0d_addr", i), qAt(txAddr, i), s3Exp[i]);
      end

      // Fetch cancelled while the memory is still working on it.
      clearLogs();
      memWait = 3;
      applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      tick();
      if_cancel = 1'b1;
      if_addr   = 32'hA0;
      tick();
      if_cancel = 1'b0;
      serveRequests(1, 0, 40);
      repeat (2) tick();
      checkOutput("s4_tx_count", txAddr.size(), 2);
      checkOutput("s4_first_addr", qAt(txAddr, 0), 32'h80);
      checkOutput("s4_second_addr", qAt(txAddr, 1), 32'hA0);
      checkOutput("s4_if_acks", ifAckCyc.size(), 1);
      checkOutput("s4_if_rdata", qAt(ifAckData, 0), 32'hA5A5_00A0);
      checkOutput("s4_req_cycles", memReqCycles, 8);

      // Cancel arriving in the very cycle the memory acks.
      clearLogs();
      memWait = 1;
      applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      tick();
      if_cancel = 1'b1;
      if_req    = 1'b0;
      tick();
      if_cancel = 1'b0;
      repeat (2) tick();
      checkOutput("s5_if_acks", ifAckCyc.size(), 0);
      checkOutput("s5_tx_count", txAddr.size(), 1);
      checkOutput("s5_req_cycles", memReqCycles, 2);

      // Reset during a store with a saturated burst count.
      clearLogs();
      memWait = 3;
      applyStimulus(1'b1, 32'h500, 1'b0, 1'b1, 1'b1, 4'b1100, 32'h400, 32'h1122_3344);
      dmGot = 0;
      for (int i = 0; i < 60 && dmGot < 3; i++) begin
         tick();
         if (lastDmAck) begin
            dmGot++;
            dm_addr = dm_addr + 32'd4;
         end
      end
      checkOutput("s6_pre_dm_acks", dmGot, 3);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checkResetValues("s6");
      tick();
      tick();
      rst_n = 1'b1;
      clearLogs();
      serveRequests(1, 1, 60);
      repeat (2) tick();
      checkOutput("s6_tx_count", txAddr.size(), 2);
      checkOutput("s6_first_addr", qAt(txAddr, 0), 32'h40C);
      checkOutput("s6_first_we_be", qAt(txAttr, 0), 32'h1C);
      checkOutput("s6_second_addr", qAt(txAddr, 1), 32'h500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
